// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory slice.
// Optional misaligned-access trapping is enabled with DMEM_MISALIGN_TRAP_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // funct3[1:0] encodes the access size, funct3[2] selects zero extension
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);
  localparam int BYTE_W     = 8;

  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane steering for the data memory: store byte enables and lane-aligned
// data, load byte/halfword extraction with sign or zero extension.
module dmem_byte_lane
  import dmem_pkg::*;
(
  input  logic [2:0]            funct3_i,
  input  logic [LANE_W-1:0]     lane_i,
  input  logic [31:0]           wr_data_i,
  input  logic [31:0]           rd_word_i,
  output logic [WORD_BYTES-1:0] be_o,
  output logic [31:0]           wr_word_o,
  output logic [31:0]           ld_data_o,
  output logic                  err_o
);

  logic              trap;
  logic [LANE_W-1:0] lane;
  logic [31:0]       shifted;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = f3_supported(funct3_i) &&
                (((funct3_i[1:0] == SZ_HALF) && lane_i[0]) ||
                 ((funct3_i[1:0] == SZ_WORD) && (lane_i != '0)));
`else
  assign trap = 1'b0;
`endif

  assign err_o = trap;

  // Without trapping, low address bits are forced to natural alignment
  always_comb begin
    lane = lane_i;
    case (funct3_i[1:0])
      SZ_HALF: lane = {lane_i[1], 1'b0};
      SZ_WORD: lane = '0;
      default: lane = lane_i;
    endcase

    shifted   = rd_word_i >> {lane, 3'b000};
    wr_word_o = wr_data_i << {lane, 3'b000};
    be_o      = '0;
    ld_data_o = '0;

    if (f3_supported(funct3_i) && !trap) begin
      case (funct3_i[1:0])
        SZ_BYTE: begin
          be_o      = 4'b0001 << lane;
          ld_data_o = {{24{shifted[7] & ~funct3_i[2]}}, shifted[7:0]};
        end
        SZ_HALF: begin
          be_o      = 4'b0011 << lane;
          ld_data_o = {{16{shifted[15] & ~funct3_i[2]}}, shifted[15:0]};
        end
        default: begin
          be_o      = 4'b1111;
          ld_data_o = rd_word_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: IDLE/WAIT/RESP handshake over a word array
// with byte-lane stores. Misaligned trapping is enabled by DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rvalid,
  output logic              busy,
  output logic              err
);

  localparam int         DEPTH    = 2 ** (ADDR_W - LANE_W);
  localparam logic [3:0] LAST_CNT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              store_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rvalid_q;
  logic              busy_q;
  logic              err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic                  accept;
  logic                  enter_resp;
  logic                  acc_store;
  logic [ADDR_W-1:0]     acc_addr;
  logic [2:0]            acc_funct3;
  logic [DATA_W-1:0]     acc_wdata;
  logic [WORD_BYTES-1:0] be_d;
  logic [DATA_W-1:0]     wr_word_d;
  logic [DATA_W-1:0]     ld_data_d;
  logic                  lane_err_d;

  assign accept     = (state_q == ST_IDLE) && (rd || wr);
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == LAST_CNT));

  // With no wait states the access resolves on its acceptance edge, so the
  // live request bypasses the capture registers while idle.
  assign acc_store  = (state_q == ST_IDLE) ? wr      : store_q;
  assign acc_addr   = (state_q == ST_IDLE) ? addr    : addr_q;
  assign acc_funct3 = (state_q == ST_IDLE) ? funct3  : funct3_q;
  assign acc_wdata  = (state_q == ST_IDLE) ? wr_data : wr_data_q;

  dmem_byte_lane u_lane (
    .funct3_i  (acc_funct3),
    .lane_i    (acc_addr[LANE_W-1:0]),
    .wr_data_i (acc_wdata),
    .rd_word_i (mem_q[acc_addr[ADDR_W-1:LANE_W]]),
    .be_o      (be_d),
    .wr_word_o (wr_word_d),
    .ld_data_o (ld_data_d),
    .err_o     (lane_err_d)
  );

  always_ff @(posedge clk) begin
    if (!reset && enter_resp && acc_store) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be_d[b]) begin
          mem_q[acc_addr[ADDR_W-1:LANE_W]][b*BYTE_W +: BYTE_W] <= wr_word_d[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      rvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            store_q   <= wr;
            addr_q    <= addr;
            funct3_q  <= funct3;
            wr_data_q <= wr_data;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // Loads update the result; stores leave it alone unless they trapped
      if (enter_resp) begin
        rvalid_q <= 1'b1;
        err_q    <= lane_err_d;
        if (!acc_store || lane_err_d) begin
          rd_data_q <= ld_data_d;
        end
      end
    end
  end

  assign rd_data = rd_data_q;
  assign rvalid  = rvalid_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder with zero and three wait states.
// Expectations for misaligned accesses follow DMEM_MISALIGN_TRAP_EN.
module tb_dmem_responder;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    logic        isLoad;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset0, wr0, rd0, rv0, busy0, err0;
  logic [8:0]  addr0;
  logic [2:0]  f30;
  logic [31:0] wd0, rdd0;
  logic        reset3, wr3, rd3, rv3, busy3, err3;
  logic [8:0]  addr3;
  logic [2:0]  f33;
  logic [31:0] wd3, rdd3;

  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t q0[$];
  exp_t q3[$];
  exp_t mon0, mon3;
  exp_t ex;
  int   busyCnt, rvAt;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset0), .wr(wr0), .rd(rd0), .addr(addr0), .funct3(f30),
    .wr_data(wd0), .rd_data(rdd0), .rvalid(rv0), .busy(busy0), .err(err0)
  );

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset3), .wr(wr3), .rd(rd3), .addr(addr3), .funct3(f33),
    .wr_data(wd3), .rd_data(rdd3), .rvalid(rv3), .busy(busy3), .err(err3)
  );

  // Counts one comparison and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic setIn(input int dut, input logic w, input logic r, input logic [8:0] a,
                       input logic [2:0] f, input logic [31:0] d);
    if (dut == 0) begin
      wr0 = w; rd0 = r; addr0 = a; f30 = f; wd0 = d;
    end else begin
      wr3 = w; rd3 = r; addr3 = a; f33 = f; wd3 = d;
    end
  endtask

  // Drives one request, queues its expected response and checks the latency
  task automatic applyStimulus(input int dut, input logic w, input logic r, input logic [8:0] a,
                               input logic [2:0] f, input logic [31:0] d, input string tag,
                               input logic [31:0] expData, input logic expErr);
    exp_t e;
    int   lat;
    int   expLat;
    expLat   = (dut == 0) ? 1 : 4;
    e.tag    = tag;
    e.data   = expData;
    e.err    = expErr;
    e.isLoad = !w;
    @(negedge clk);
    setIn(dut, w, r, a, f, d);
    if (dut == 0) q0.push_back(e); else q3.push_back(e);
    @(posedge clk);
    #1;
    setIn(dut, 1'b0, 1'b0, a, f, d);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (((dut == 0) ? rv0 : rv3) === 1'b1) begin
        lat = c;
        break;
      end
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    @(posedge clk);
  endtask

  // Scoreboards: every rvalid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rv0 === 1'b1) begin
      if (q0.size() == 0) begin
        checkOutput("dut0 unexpected rvalid", 32'(rv0), 32'd0);
      end else begin
        mon0 = q0.pop_front();
        if (mon0.isLoad) checkOutput({mon0.tag, " rd_data"}, rdd0, mon0.data);
        checkOutput({mon0.tag, " err"}, 32'(err0), 32'(mon0.err));
      end
    end
  end

  always @(negedge clk) begin
    if (rv3 === 1'b1) begin
      if (q3.size() == 0) begin
        checkOutput("dut3 unexpected rvalid", 32'(rv3), 32'd0);
      end else begin
        mon3 = q3.pop_front();
        if (mon3.isLoad) checkOutput({mon3.tag, " rd_data"}, rdd3, mon3.data);
        checkOutput({mon3.tag, " err"}, 32'(err3), 32'(mon3.err));
      end
    end
  end

  initial begin
    reset0 = 1'b1;
    reset3 = 1'b1;
    setIn(0, 1'b0, 1'b0, 9'h0, 3'b0, 32'h0);
    setIn(3, 1'b0, 1'b0, 9'h0, 3'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset0 = 1'b0;
    reset3 = 1'b0;
    @(negedge clk);
    checkOutput("reset dut0 rd_data", rdd0, 32'h0);
    checkOutput("reset dut0 rvalid", 32'(rv0), 32'h0);
    checkOutput("reset dut0 busy", 32'(busy0), 32'h0);
    checkOutput("reset dut0 err", 32'(err0), 32'h0);
    checkOutput("reset dut3 busy", 32'(busy3), 32'h0);

    applyStimulus(0, 1'b1, 1'b0, 9'h010, 3'b010, 32'hDEADBEEF, "SW 0x010", 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 9'h010, 3'b010, 32'h0, "LW 0x010", 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 9'h011, 3'b000, 32'h00000080, "SB 0x011", 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 9'h011, 3'b000, 32'h0, "LB 0x011", 32'hFFFFFF80, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 9'h011, 3'b100, 32'h0, "LBU 0x011", 32'h00000080, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 9'h010, 3'b010, 32'h0, "LW merged", 32'hDEAD80EF, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    applyStimulus(0, 1'b0, 1'b1, 9'h013, 3'b010, 32'h0, "LW 0x013", 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 1'b1, 9'h011, 3'b001, 32'h0, "LH 0x011", 32'h0, 1'b1);
`else
    applyStimulus(0, 1'b0, 1'b1, 9'h013, 3'b010, 32'h0, "LW 0x013", 32'hDEAD80EF, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 9'h011, 3'b001, 32'h0, "LH 0x011", 32'hFFFF80EF, 1'b0);
`endif
    applyStimulus(0, 1'b1, 1'b0, 9'h016, 3'b001, 32'h1234ABCD, "SH 0x016", 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 9'h016, 3'b001, 32'h0, "LH 0x016", 32'hFFFFABCD, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 9'h016, 3'b101, 32'h0, "LHU 0x016", 32'h0000ABCD, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 9'h010, 3'b011, 32'h0, "load f3=011", 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 9'h010, 3'b111, 32'h0, "store f3=111", 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 9'h010, 3'b010, 32'h0, "LW after bad store", 32'hDEAD80EF, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 9'h1FC, 3'b010, 32'hA5A5A5A5, "rd+wr SW 0x1FC", 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("rd_data hold over store", rdd0, 32'hDEAD80EF);
    applyStimulus(0, 1'b0, 1'b1, 9'h1FC, 3'b010, 32'h0, "LW 0x1FC", 32'hA5A5A5A5, 1'b0);

    applyStimulus(3, 1'b1, 1'b0, 9'h010, 3'b010, 32'hDEADBEEF, "w3 SW 0x010", 32'h0, 1'b0);
    applyStimulus(3, 1'b1, 1'b0, 9'h020, 3'b010, 32'h11112222, "w3 SW 0x020", 32'h0, 1'b0);

    // LH with three wait states while the requester keeps rd asserted during busy
    ex.tag = "w3 LH 0x012"; ex.data = 32'hFFFFDEAD; ex.err = 1'b0; ex.isLoad = 1'b1;
    @(negedge clk);
    setIn(3, 1'b0, 1'b1, 9'h012, 3'b001, 32'h0);
    q3.push_back(ex);
    @(posedge clk);
    #1;
    setIn(3, 1'b0, 1'b0, 9'h012, 3'b001, 32'h0);
    busyCnt = 0;
    rvAt = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (busy3 === 1'b1) busyCnt++;
      if (rv3 === 1'b1 && rvAt < 0) rvAt = c;
      setIn(3, 1'b0, busy3, 9'h010, 3'b010, 32'h0);
    end
    setIn(3, 1'b0, 1'b0, 9'h010, 3'b010, 32'h0);
    checkOutput("w3 LH busy cycles", 32'(busyCnt), 32'd4);
    checkOutput("w3 LH rvalid cycle", 32'(rvAt), 32'd4);

    // Store aborted by reset in its second wait cycle
    @(negedge clk);
    setIn(3, 1'b1, 1'b0, 9'h020, 3'b010, 32'h12345678);
    @(posedge clk);
    #1;
    setIn(3, 1'b0, 1'b0, 9'h020, 3'b010, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset3 = 1'b1;
    @(posedge clk);
    #1;
    reset3 = 1'b0;
    @(negedge clk);
    checkOutput("abort rd_data", rdd3, 32'h0);
    checkOutput("abort rvalid", 32'(rv3), 32'h0);
    checkOutput("abort busy", 32'(busy3), 32'h0);
    checkOutput("abort err", 32'(err3), 32'h0);
    repeat (5) @(negedge clk);
    applyStimulus(3, 1'b0, 1'b1, 9'h020, 3'b010, 32'h0, "w3 LW 0x020", 32'h11112222, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("dut0 queue drained", 32'(q0.size()), 32'd0);
    checkOutput("dut3 queue drained", 32'(q3.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
